// File: rtl/ultra_sonic_emu.sv
// HC-SR04-style ultrasonic sensor emulator: validates a trigger pulse, then returns an echo whose
// width encodes dist_cm. Optional echo jitter via `define ULTRA_SONIC_EMU_JITTER_EN.
module ultra_sonic_emu #(
   parameter int unsigned TRIG_MIN_CYC = 500,
   parameter int unsigned BURST_CYC    = 22500,
   parameter int unsigned CYC_PER_CM   = 2610,
   parameter int unsigned MAX_CM       = 400,
   parameter int unsigned TIMEOUT_CYC  = 1900000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic [19:0] dist_cm,
   output logic        dur,
   output logic        busy,
   output logic        trig_err
);

   typedef enum logic [1:0] {StIdle, StTrig, StBurst, StEcho} state_e;

   state_e      state;
   logic        t1, t2;
   logic        sync_vld;
   logic        armed;
   logic [31:0] hi_cnt;
   logic [31:0] dly_cnt;
   logic [31:0] echo_cnt;
   logic [31:0] n_q;
   logic [19:0] dist_q;
   logic        rise, fall;
   logic        out_of_range;
   logic [31:0] n_exact;
   logic [31:0] n_calc;

   assign rise = t1 & ~t2;
   assign fall = ~t1 & t2;

   always_comb begin
      out_of_range = 32'(dist_q) > MAX_CM;
      if (dist_q == '0) begin
         n_exact = CYC_PER_CM;
      end else if (!out_of_range) begin
         n_exact = 32'(dist_q) * CYC_PER_CM;
      end else begin
         n_exact = TIMEOUT_CYC;
      end
   end

`ifdef ULTRA_SONIC_EMU_JITTER_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign n_calc = out_of_range ? n_exact : n_exact + {24'd0, lfsr[7:0]};
`else
   assign n_calc = n_exact;
`endif

   // armed blocks a trigger that was already high when reset released from counting as a rise
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         t1       <= 1'b0;
         t2       <= 1'b0;
         sync_vld <= 1'b0;
         armed    <= 1'b0;
         hi_cnt   <= '0;
         dly_cnt  <= '0;
         echo_cnt <= '0;
         n_q      <= '0;
         dist_q   <= '0;
         dur      <= 1'b0;
         busy     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         t1       <= trigger;
         t2       <= t1;
         sync_vld <= 1'b1;
         trig_err <= 1'b0;
         if (sync_vld && !t1) armed <= 1'b1;

         case (state)
            StIdle: begin
               if (rise && armed) begin
                  state  <= StTrig;
                  hi_cnt <= 32'd1;
               end
            end
            StTrig: begin
               if (fall) begin
                  if (hi_cnt >= TRIG_MIN_CYC) begin
                     state   <= StBurst;
                     busy    <= 1'b1;
                     dist_q  <= dist_cm;
                     dly_cnt <= '0;
                  end else begin
                     trig_err <= 1'b1;
                     state    <= StIdle;
                  end
               end else if (t1 && hi_cnt < TRIG_MIN_CYC) begin
                  hi_cnt <= hi_cnt + 32'd1;
               end
            end
            StBurst: begin
               // dist_q settles on the entry edge, so the width is captured on the first cycle
               if (dly_cnt == '0) n_q <= n_calc;
               if (dly_cnt == BURST_CYC - 1) begin
                  state    <= StEcho;
                  dur      <= 1'b1;
                  echo_cnt <= '0;
               end else begin
                  dly_cnt <= dly_cnt + 32'd1;
               end
            end
            StEcho: begin
               if (echo_cnt == n_q - 32'd1) begin
                  dur   <= 1'b0;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  echo_cnt <= echo_cnt + 32'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ultra_sonic_emu.sv
// Randomized bench for ultra_sonic_emu with scaled-down timing constants and an event-level
// reference model (expected edge times and widths derived from the sensor's rules).
module tb_ultra_sonic_emu;

   localparam int TMIN  = 8;
   localparam int BURST = 20;
   localparam int CPC   = 3;
   localparam int MAXCM = 40;
   localparam int TOUT  = 200;
`ifdef ULTRA_SONIC_EMU_JITTER_EN
   localparam int JIT = 256;
`else
   localparam int JIT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trigger = 1'b0;
   logic [19:0] dist_cm = '0;
   logic        dur, busy, trig_err;

   always #5 clk = ~clk;

   ultra_sonic_emu #(
      .TRIG_MIN_CYC(TMIN),
      .BURST_CYC   (BURST),
      .CYC_PER_CM  (CPC),
      .MAX_CM      (MAXCM),
      .TIMEOUT_CYC (TOUT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .trigger (trigger),
      .dist_cm (dist_cm),
      .dur     (dur),
      .busy    (busy),
      .trig_err(trig_err)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   // Observed events, sampled on the falling edge
   int rise_q[$], width_q[$], brise_q[$], bwidth_q[$];
   int err_cycles = 0;
   int err_at = -1;
   bit dur_p = 1'b0, busy_p = 1'b0;
   int dur_s = 0, busy_s = 0;

   always @(negedge clk) begin
      if (rst) begin
         dur_p  = 1'b0;
         busy_p = 1'b0;
      end else begin
         if (dur && !dur_p) begin rise_q.push_back(cyc); dur_s = cyc; end
         if (!dur && dur_p) width_q.push_back(cyc - dur_s);
         if (busy && !busy_p) begin brise_q.push_back(cyc); busy_s = cyc; end
         if (!busy && busy_p) bwidth_q.push_back(cyc - busy_s);
         if (trig_err) begin err_cycles++; err_at = cyc; end
         dur_p  = dur;
         busy_p = busy;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic int ref_n(input int d);
      if (d == 0) return CPC;
      if (d <= MAXCM) return d * CPC;
      return TOUT;
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic flush();
      rise_q.delete();
      width_q.delete();
      brise_q.delete();
      bwidth_q.delete();
   endtask

   task automatic pulse(input int hi, output int c);
      @(negedge clk);
      trigger = 1'b1;
      repeat (hi) @(negedge clk);
      trigger = 1'b0;
      c = cyc;
   endtask

   task automatic check_echo(input int c, input int d);
      int n, w, bw;
      n = ref_n(d);
      check_eq("rise_cyc", rise_q.size() > 0 ? rise_q.pop_front() : -1, c + BURST + 2);
      w = width_q.size() > 0 ? width_q.pop_front() : -1;
`ifdef ULTRA_SONIC_EMU_JITTER_EN
      if (d > MAXCM) check_eq("width", w, n);
      else check_eq("width_jit", (w >= n && w <= n + 255) ? 1 : 0, 1);
      n = w;
`else
      check_eq("width", w, n);
`endif
      check_eq("busy_rise", brise_q.size() > 0 ? brise_q.pop_front() : -1, c + 2);
      bw = bwidth_q.size() > 0 ? bwidth_q.pop_front() : -1;
      check_eq("busy_width", bw, BURST + n);
   endtask

   task automatic measure(input int hi, input int d);
      int c, e0;
      e0 = err_cycles;
      dist_cm = 20'(d);
      pulse(hi, c);
      repeat (3) @(negedge clk);
      dist_cm = 20'($urandom_range(0, 1000));
      repeat (BURST + ref_n(d) + JIT + 6) @(negedge clk);
      check_echo(c, d);
      check_eq("no_trig_err", err_cycles - e0, 0);
   endtask

   task automatic short_trig(input int hi);
      int c, e0;
      e0 = err_cycles;
      pulse(hi, c);
      repeat (10) @(negedge clk);
      check_eq("err_pulses", err_cycles - e0, 1);
      check_eq("err_at", err_at, c + 2);
      check_eq("short_no_echo", rise_q.size(), 0);
      check_eq("short_no_busy", brise_q.size(), 0);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("rst_dur", int'(dur), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_err", int'(trig_err), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      measure(12, 10);
      measure(TMIN, 0);
      measure(TMIN, MAXCM);
      measure(TMIN + 3, MAXCM + 1);
      measure(9, 1048575);
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 3) == 0) short_trig($urandom_range(1, TMIN - 1));
         else measure($urandom_range(TMIN, TMIN + 12), $urandom_range(0, 60));
      end
      short_trig(TMIN - 1);
      measure(11, 7);

      // Retrigger and distance change during the echo must not disturb it
      begin
         int e0;
         e0 = err_cycles;
         dist_cm = 20'd20;
         pulse(10, c);
         repeat (BURST + 8) @(negedge clk);
         dist_cm = 20'd5;
         trigger = 1'b1;
         repeat (3) @(negedge clk);
         trigger = 1'b0;
         repeat (5) @(negedge clk);
         trigger = 1'b1;
         repeat (12) @(negedge clk);
         trigger = 1'b0;
         repeat (ref_n(20) + JIT + 40) @(negedge clk);
         check_eq("retrig_echoes", rise_q.size(), 1);
         check_echo(c, 20);
         check_eq("retrig_no_err", err_cycles - e0, 0);
      end

      // Reset mid-echo, trigger held high across reset release
      dist_cm = 20'd10;
      pulse(10, c);
      repeat (BURST + 12) @(negedge clk);
      check_eq("mid_echo_dur", int'(dur), 1);
      trigger = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_mid_dur", int'(dur), 0);
      check_eq("rst_mid_busy", int'(busy), 0);
      flush();
      repeat (40) @(negedge clk);
      check_eq("held_no_echo", rise_q.size(), 0);
      check_eq("held_no_busy", brise_q.size(), 0);
      trigger = 1'b0;
      repeat (3) @(negedge clk);
      measure(10, 15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
